// File: rtl/fpmul_share_arbiter_if.sv
// Handshake bundle between operand sources, the shared FP multiplier and the
// response consumer of fpmul_share_arbiter.
interface fpmul_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_z;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_z, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_z, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/fpmul_share_arbiter.sv
// Round-robin sharing of one pipelined FP multiplier among NUM_REQ requesters,
// with an ID tag pipe, an in-order response FIFO and credit-based admission.
module fpmul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fpmul_share_arbiter_if.slave  bus_io
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic           gnt_found;
  logic           credit_ok;
  logic           accept;

  logic [31:0]    mul_a_q, mul_b_q;
  logic           acc_vld_q;
  logic [IDW-1:0] acc_id_q;
  logic [MUL_LATENCY-1:0] tag_vld_q;
  logic [IDW-1:0] tag_id_q [MUL_LATENCY];

  logic [31:0]    fifo_data_q [FIFO_DEPTH];
  logic [IDW-1:0] fifo_id_q   [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  outstanding_q;
  logic           fifo_wr;
  logic           fifo_pop;
  logic           fifo_nonempty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Scan upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NUM_REQ)) scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
      scan_idx = scan_sum[IDW-1:0];
      if (!gnt_found && bus_io.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
    rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
  end

  assign credit_ok     = (outstanding_q < CW'(FIFO_DEPTH));
  assign accept        = gnt_found && credit_ok && !rst;
  assign fifo_nonempty = (count_q != '0);
  assign fifo_pop      = fifo_nonempty && bus_io.rsp_ready;
  assign fifo_wr       = tag_vld_q[MUL_LATENCY-1];

  assign bus_io.req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;
  assign bus_io.mul_a     = mul_a_q;
  assign bus_io.mul_b     = mul_b_q;
  assign bus_io.rsp_valid = fifo_nonempty;
  assign bus_io.rsp_data  = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
  assign bus_io.rsp_id    = fifo_nonempty ? fifo_id_q[rd_ptr_q] : '0;
  assign bus_io.busy      = (outstanding_q != '0);

  // Stage boundary: accept -> operand registers / tag pipe -> FIFO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      acc_vld_q     <= 1'b0;
      tag_vld_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q <= rr_ptr_d;
        mul_a_q  <= bus_io.req_a[32*gnt_id +: 32];
        mul_b_q  <= bus_io.req_b[32*gnt_id +: 32];
      end
      acc_vld_q    <= accept;
      tag_vld_q[0] <= acc_vld_q;
      for (int k = 1; k < MUL_LATENCY; k++) tag_vld_q[k] <= tag_vld_q[k-1];
      if (fifo_wr)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({fifo_wr, fifo_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      unique case ({accept, fifo_pop})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Data path registers carry no reset; their valids are cleared above.
  always_ff @(posedge clk) begin
    acc_id_q    <= gnt_id;
    tag_id_q[0] <= acc_id_q;
    for (int k = 1; k < MUL_LATENCY; k++) tag_id_q[k] <= tag_id_q[k-1];
    if (fifo_wr) begin
      fifo_data_q[wr_ptr_q] <= bus_io.mul_z;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[MUL_LATENCY-1];
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !fifo_pop && (count_q == CW'(FIFO_DEPTH))))
    else $error("response FIFO overflow");
endmodule

// File: tb/tb_fpmul_share_arbiter.sv
// Directed bench for fpmul_share_arbiter with a 4-stage behavioural FP multiplier.
module tb_fpmul_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpmul_share_arbiter_if #(.NUM_REQ(4)) bus ();

  fpmul_share_arbiter #(.NUM_REQ(4), .MUL_LATENCY(4), .FIFO_DEPTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Behavioural multiplier: normals (truncating), zero, inf, NaN.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [9:0]  e;
    logic        a_zero, b_zero, a_inf, b_inf;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  logic [31:0] m_q [4];
  always @(posedge clk) begin
    m_q[0] <= fmul(bus.mul_a, bus.mul_b);
    m_q[1] <= m_q[0];
    m_q[2] <= m_q[1];
    m_q[3] <= m_q[2];
  end
  assign bus.mul_z = m_q[3];

  logic [31:0] got_data [$];
  logic [1:0]  got_id   [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic collect(input int budget);
    got_data.delete();
    got_id.delete();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (bus.rsp_valid) begin
        got_data.push_back(bus.rsp_data);
        got_id.push_back(bus.rsp_id);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    step();
    step();
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.mul_a !== 32'h0) begin errors++; $display("FAIL reset_mul_a got=%h exp=0", bus.mul_a); end
    checks++; if (bus.mul_b !== 32'h0) begin errors++; $display("FAIL reset_mul_b got=%h exp=0", bus.mul_b); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    bus.req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.rsp_ready = 1'b1;
    set_op(0, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    checks++; if (bus.mul_a !== 32'h3FC00000) begin errors++; $display("FAIL single_mul_a got=%h exp=3fc00000", bus.mul_a); end
    checks++; if (bus.mul_b !== 32'h40000000) begin errors++; $display("FAIL single_mul_b got=%h exp=40000000", bus.mul_b); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL single_latency got=%0d exp=6", n); end
    checks++; if (bus.rsp_data !== 32'h40400000) begin errors++; $display("FAIL single_data got=%h exp=40400000", bus.rsp_data); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", bus.rsp_id); end
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_popped got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_z [4];
    logic [3:0]  exp_rdy;
    exp_z = '{32'h40000000, 32'h40800000, 32'h3F800000, 32'h40400000};
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h3F000000, 32'h40000000);
    set_op(3, 32'h3FC00000, 32'h40000000);
    got_data.delete();
    got_id.delete();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 40; k++) begin
      if (bus.rsp_valid) begin
        got_data.push_back(bus.rsp_data);
        got_id.push_back(bus.rsp_id);
      end
      if (k < 8) begin
        exp_rdy = 4'b0001 << (k % 4);
        checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
      end
      step();
      if (k == 7) bus.req_valid = '0;
    end
    checks++; if (got_id.size() != 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", got_id.size()); end
    for (int j = 0; j < got_id.size() && j < 8; j++) begin
      checks++; if (got_id[j] !== 2'(j % 4) || got_data[j] !== exp_z[j % 4]) begin
        errors++; $display("FAIL rr_rsp%0d got=%0d/%h exp=%0d/%h", j, got_id[j], got_data[j], j % 4, exp_z[j % 4]);
      end
    end
  endtask

  task automatic test_credit();
    int acc;
    do_reset();
    bus.rsp_ready = 1'b0;
    set_op(1, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0010;
    #1;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.req_ready[1]) acc++;
      step();
    end
    checks++; if (acc != 8) begin errors++; $display("FAIL credit_accepts got=%0d exp=8", acc); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL credit_stall got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL credit_full_valid got=%b exp=1", bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL credit_same_cycle got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'h40C00000) begin
      errors++; $display("FAIL credit_head got=%0d/%h exp=1/40c00000", bus.rsp_id, bus.rsp_data);
    end
    step();
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL credit_reopen got=%b exp=0010", bus.req_ready); end
    step();
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL credit_one_only got=%b exp=0000", bus.req_ready); end
    bus.req_valid = '0;
    collect(30);
    checks++; if (got_id.size() != 8) begin errors++; $display("FAIL credit_drain got=%0d exp=8", got_id.size()); end
    for (int j = 0; j < got_id.size(); j++) begin
      checks++; if (got_id[j] !== 2'd1 || got_data[j] !== 32'h40C00000) begin
        errors++; $display("FAIL credit_rsp%0d got=%0d/%h exp=1/40c00000", j, got_id[j], got_data[j]);
      end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL credit_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_rr_pointer();
    do_reset();
    bus.rsp_ready = 1'b0;
    set_op(0, 32'h3F800000, 32'hC0200000);
    set_op(2, 32'h3F000000, 32'h40800000);
    set_op(3, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL ptr_first got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = 4'b1001;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_wrap3 got=%b exp=1000", bus.req_ready); end
    step();
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL ptr_then0 got=%b exp=0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    collect(20);
    checks++; if (got_id.size() != 3) begin errors++; $display("FAIL ptr_count got=%0d exp=3", got_id.size()); end
    else begin
      checks++; if (got_id[0] !== 2'd2 || got_data[0] !== 32'h40000000) begin errors++; $display("FAIL ptr_rsp0 got=%0d/%h exp=2/40000000", got_id[0], got_data[0]); end
      checks++; if (got_id[1] !== 2'd3 || got_data[1] !== 32'h40400000) begin errors++; $display("FAIL ptr_rsp1 got=%0d/%h exp=3/40400000", got_id[1], got_data[1]); end
      checks++; if (got_id[2] !== 2'd0 || got_data[2] !== 32'hC0200000) begin errors++; $display("FAIL ptr_rsp2 got=%0d/%h exp=0/c0200000", got_id[2], got_data[2]); end
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    do_reset();
    bus.rsp_ready = 1'b1;
    set_op(0, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0001;
    step();
    step();
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mul_a !== 32'h0) begin errors++; $display("FAIL midrst_mul_a got=%h exp=0", bus.mul_a); end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.rsp_valid) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale_rsp got=%0d exp=0", seen); end
    set_op(1, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0011;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant got=%b exp=0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    collect(20);
    checks++; if (got_id.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", got_id.size()); end
    else begin
      checks++; if (got_id[0] !== 2'd0 || got_data[0] !== 32'h40400000) begin errors++; $display("FAIL midrst_rsp got=%0d/%h exp=0/40400000", got_id[0], got_data[0]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] exp_z [4];
    logic [1:0]  exp_i [4];
    exp_z = '{32'h7FC00000, 32'h40000000, 32'hC0200000, 32'h40C00000};
    exp_i = '{2'd1, 2'd2, 2'd0, 2'd1};
    do_reset();
    bus.rsp_ready = 1'b0;
    set_op(1, 32'h7F800000, 32'h00000000);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL spec_g0 got=%b exp=0010", bus.req_ready); end
    step();
    set_op(0, 32'h3F800000, 32'hC0200000);
    set_op(2, 32'h3F000000, 32'h40800000);
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL spec_g1 got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL spec_g2 got=%b exp=0001", bus.req_ready); end
    step();
    set_op(1, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL spec_g3 got=%b exp=0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    collect(25);
    checks++; if (got_id.size() != 4) begin errors++; $display("FAIL spec_count got=%0d exp=4", got_id.size()); end
    for (int j = 0; j < got_id.size() && j < 4; j++) begin
      checks++; if (got_id[j] !== exp_i[j] || got_data[j] !== exp_z[j]) begin
        errors++; $display("FAIL spec_rsp%0d got=%0d/%h exp=%0d/%h", j, got_id[j], got_data[j], exp_i[j], exp_z[j]);
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_rr_pointer();
    test_mid_reset();
    test_special();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
